esp32_osd_write_ctrl: RTL and testbench

ESP32_OSD_WRITE_CTRL -- requirements
Module: esp32_osd_write_ctrl

---
 rtl/osd_pkg.sv | 15 +
 rtl/esp32_osd_fill_engine.sv | 68 ++++++
 rtl/esp32_osd_write_ctrl.sv | 119 +++++++++++
 tb/tb_esp32_osd_write_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared constants and FSM state type for the OSD buffer write path.
package osd_pkg;

  localparam int OSD_ADDR_W     = 12;
  localparam int OSD_TEXT_BYTES = 512;
  localparam int OSD_LINE_CHARS = 32;
  localparam int OSD_DATA_W     = 8;

  // IDLE arbitrates the two requesters, CLEAR hands the write port to the fill engine.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } osd_state_e;

endpackage

// File: rtl/esp32_osd_fill_engine.sv
// Fill sequencer: walks TEXT_BYTES consecutive addresses from FILL_BASE with one
// latched character, then spends one drain cycle while the last write leaves the
// output register, then pulses done.
module esp32_osd_fill_engine
  import osd_pkg::*;
#(
  parameter int                ADDR_W     = OSD_ADDR_W,
  parameter int                TEXT_BYTES = OSD_TEXT_BYTES,
  parameter logic [ADDR_W-1:0] FILL_BASE  = '0
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OSD_DATA_W-1:0] char_in,
  output logic                  fill_we,
  output logic [ADDR_W-1:0]     fill_addr,
  output logic [OSD_DATA_W-1:0] fill_data,
  output logic                  busy,
  output logic                  drain,
  output logic                  done
);

  localparam int               CNT_W    = (TEXT_BYTES > 1) ? $clog2(TEXT_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TEXT_BYTES - 1);

  logic [CNT_W-1:0]      cnt_p0;
  logic [OSD_DATA_W-1:0] char_p0;
  logic                  busy_p0;
  logic                  drain_p1;
  logic                  done_p2;

  // Counter, latched character and the busy -> drain -> done sequence.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      char_p0  <= '0;
      busy_p0  <= 1'b0;
      drain_p1 <= 1'b0;
      done_p2  <= 1'b0;
    end else begin
      // p0 -> p1: last fill write issued, output register still holds it
      drain_p1 <= busy_p0 && (cnt_p0 == CNT_LAST);
      // p1 -> p2: done follows the cycle in which the final write was visible
      done_p2  <= drain_p1;
      if (start) begin
        busy_p0 <= 1'b1;
        cnt_p0  <= '0;
        char_p0 <= char_in;
      end else if (busy_p0) begin
        if (cnt_p0 == CNT_LAST) begin
          busy_p0 <= 1'b0;
          cnt_p0  <= '0;
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

  // Address arithmetic wraps naturally at 2^ADDR_W.
  assign fill_we   = busy_p0;
  assign fill_addr = FILL_BASE + ADDR_W'(cnt_p0);
  assign fill_data = char_p0;
  assign busy      = busy_p0;
  assign drain     = drain_p1;
  assign done      = done_p2;

endmodule

// File: rtl/esp32_osd_write_ctrl.sv
// OSD buffer write controller: round-robin arbiter between the SPI and status-line
// requesters, plus a fill engine that takes over the write port to clear the text
// area. All write-port outputs and acks are registered.
module esp32_osd_write_ctrl
  import osd_pkg::*;
#(
  parameter int                ADDR_W     = OSD_ADDR_W,
  parameter int                TEXT_BYTES = OSD_TEXT_BYTES,
  parameter logic [ADDR_W-1:0] FILL_BASE  = '0
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  spi_req,
  input  logic [ADDR_W-1:0]     spi_addr,
  input  logic [OSD_DATA_W-1:0] spi_data,
  output logic                  spi_ack,
  input  logic                  stat_req,
  input  logic [ADDR_W-1:0]     stat_addr,
  input  logic [OSD_DATA_W-1:0] stat_data,
  output logic                  stat_ack,
  input  logic                  clr_start,
  input  logic [OSD_DATA_W-1:0] clr_char,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [OSD_DATA_W-1:0] wr_data,
  output logic                  wr_en
);

  osd_state_e            state_q, state_d;
  logic                  rr_stat_next;
  logic                  spi_elig, stat_elig;
  logic                  grant_spi, grant_stat;
  logic                  fill_start, fill_we, fill_busy, fill_drain, fill_done;
  logic [ADDR_W-1:0]     fill_addr;
  logic [OSD_DATA_W-1:0] fill_data;

  esp32_osd_fill_engine #(
    .ADDR_W     (ADDR_W),
    .TEXT_BYTES (TEXT_BYTES),
    .FILL_BASE  (FILL_BASE)
  ) u_fill (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .start     (fill_start),
    .char_in   (clr_char),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .busy      (fill_busy),
    .drain     (fill_drain),
    .done      (fill_done)
  );

  assign clr_busy = fill_busy;
  assign clr_done = fill_done;

  // FSM state register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and grant decode; a requester whose ack is high this cycle is
  // already served and must not be granted again.
  always_comb begin
    state_d    = state_q;
    fill_start = 1'b0;
    grant_spi  = 1'b0;
    grant_stat = 1'b0;
    spi_elig   = spi_req  && !spi_ack;
    stat_elig  = stat_req && !stat_ack;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          fill_start = 1'b1;
          state_d    = ST_CLEAR;
        end else if (spi_elig && (!stat_elig || !rr_stat_next)) begin
          grant_spi = 1'b1;
        end else if (stat_elig) begin
          grant_stat = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (fill_drain) state_d = ST_IDLE;
      end
    endcase
  end

  // Registered write port, acks and round-robin pointer.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      spi_ack      <= 1'b0;
      stat_ack     <= 1'b0;
      rr_stat_next <= 1'b0;
    end else begin
      // decode -> p1: registered write presented to the buffer
      wr_en    <= fill_we || grant_spi || grant_stat;
      spi_ack  <= grant_spi;
      stat_ack <= grant_stat;
      if (fill_we) begin
        wr_addr <= fill_addr;
        wr_data <= fill_data;
      end else if (grant_spi) begin
        wr_addr <= spi_addr;
        wr_data <= spi_data;
      end else if (grant_stat) begin
        wr_addr <= stat_addr;
        wr_data <= stat_data;
      end
      if (grant_spi)       rr_stat_next <= 1'b1;
      else if (grant_stat) rr_stat_next <= 1'b0;
    end
  end

endmodule

// File: tb/tb_esp32_osd_write_ctrl.sv
// Bench for esp32_osd_write_ctrl: two instances (fill base 0x000 and 0xF00) share
// all inputs; a cycle-offset model predicts every output each cycle.
module tb_esp32_osd_write_ctrl;

  localparam int TB_BYTES = 512;
  localparam int BASE0    = 0;
  localparam int BASE1    = 12'hF00;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b0;
  logic        spi_req = 1'b0, stat_req = 1'b0, clr_start = 1'b0;
  logic [11:0] spi_addr = '0, stat_addr = '0;
  logic [7:0]  spi_data = '0, stat_data = '0, clr_char = '0;

  logic        wr_en0, spi_ack0, stat_ack0, clr_busy0, clr_done0;
  logic [11:0] wr_addr0;
  logic [7:0]  wr_data0;
  logic        wr_en1, spi_ack1, stat_ack1, clr_busy1, clr_done1;
  logic [11:0] wr_addr1;
  logic [7:0]  wr_data1;

  esp32_osd_write_ctrl dut0 (
    .clk_sys(clk_sys), .rst(rst),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_data(spi_data), .spi_ack(spi_ack0),
    .stat_req(stat_req), .stat_addr(stat_addr), .stat_data(stat_data), .stat_ack(stat_ack0),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy0), .clr_done(clr_done0),
    .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_en(wr_en0)
  );

  esp32_osd_write_ctrl #(.FILL_BASE(12'hF00)) dut1 (
    .clk_sys(clk_sys), .rst(rst),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_data(spi_data), .spi_ack(spi_ack1),
    .stat_req(stat_req), .stat_addr(stat_addr), .stat_data(stat_data), .stat_ack(stat_ack1),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(clr_busy1), .clr_done(clr_done1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1)
  );

  always #10 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t counts cycles since the cycle clr_start was accepted (that cycle is t=0):
  // busy for t=1..N, fill write k visible at t=k+2, done at t=N+2, and the
  // requesters may be arbitrated again from t=N+2 onward.
  typedef struct {
    bit          en;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [7:0]  d;
    bit          sack;
    bit          tack;
    bit          busy;
    bit          done;
    bit          fill;
    int          t;
    logic [7:0]  ch;
    bit          stat_next;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.en = 0; r.a0 = '0; r.a1 = '0; r.d = '0; r.sack = 0; r.tack = 0;
    r.busy = 0; r.done = 0; r.fill = 0; r.t = 0; r.ch = '0; r.stat_next = 0;
    return r;
  endfunction

  function automatic mstate_t model_step(mstate_t cur, bit sreq, logic [11:0] saddr,
                                         logic [7:0] sdata, bit treq, logic [11:0] taddr,
                                         logic [7:0] tdata, bit cst, logic [7:0] cch);
    mstate_t nx;
    bit can_arb, s_ok, t_ok, started;
    nx      = cur;
    can_arb = !cur.fill || (cur.t >= TB_BYTES + 2);
    s_ok    = sreq && !cur.sack;
    t_ok    = treq && !cur.tack;
    started = 1'b0;
    nx.en = 0; nx.sack = 0; nx.tack = 0;
    if (cur.fill && cur.t >= 1 && cur.t <= TB_BYTES) begin
      nx.en = 1;
      nx.a0 = 12'(BASE0 + cur.t - 1);
      nx.a1 = 12'(BASE1 + cur.t - 1);
      nx.d  = cur.ch;
    end else if (can_arb) begin
      if (cst) started = 1'b1;
      else if (s_ok && (!t_ok || !cur.stat_next)) begin
        nx.en = 1; nx.sack = 1; nx.a0 = saddr; nx.a1 = saddr; nx.d = sdata; nx.stat_next = 1;
      end else if (t_ok) begin
        nx.en = 1; nx.tack = 1; nx.a0 = taddr; nx.a1 = taddr; nx.d = tdata; nx.stat_next = 0;
      end
    end
    if (started) begin
      nx.fill = 1; nx.t = 1; nx.ch = cch;
    end else if (cur.fill) begin
      nx.t = cur.t + 1;
      if (nx.t > TB_BYTES + 2) nx.fill = 0;
    end
    nx.busy = nx.fill && nx.t >= 1 && nx.t <= TB_BYTES;
    nx.done = nx.fill && nx.t == TB_BYTES + 2;
    return nx;
  endfunction

  always @(posedge clk_sys or posedge rst) begin
    if (rst) m <= model_reset();
    else m <= model_step(m, spi_req, spi_addr, spi_data, stat_req, stat_addr, stat_data,
                         clr_start, clr_char);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_sys) begin
    if (!rst) begin
      chk("wr_en",      wr_en0,    m.en);
      chk("wr_addr",    wr_addr0,  m.a0);
      chk("wr_data",    wr_data0,  m.d);
      chk("spi_ack",    spi_ack0,  m.sack);
      chk("stat_ack",   stat_ack0, m.tack);
      chk("clr_busy",   clr_busy0, m.busy);
      chk("clr_done",   clr_done0, m.done);
      chk("b_wr_en",    wr_en1,    m.en);
      chk("b_wr_addr",  wr_addr1,  m.a1);
      chk("b_wr_data",  wr_data1,  m.d);
      chk("b_spi_ack",  spi_ack1,  m.sack);
      chk("b_stat_ack", stat_ack1, m.tack);
      chk("b_clr_busy", clr_busy1, m.busy);
      chk("b_clr_done", clr_done1, m.done);
    end
  end

  // ---------------- activity log ----------------
  int          cyc = 0;
  int          wr_count = 0, busy_count = 0, done_count = 0, done_cyc = -1;
  logic [11:0] wr_log  [0:8191];
  logic [11:0] wr_log1 [0:8191];
  logic [7:0]  wr_dlog [0:8191];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (wr_en0) begin
        wr_log[wr_count % 8192]  <= wr_addr0;
        wr_log1[wr_count % 8192] <= wr_addr1;
        wr_dlog[wr_count % 8192] <= wr_data0;
        wr_count <= wr_count + 1;
      end
      if (clr_busy0) busy_count <= busy_count + 1;
      if (clr_done0) begin
        done_count <= done_count + 1;
        done_cyc   <= cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic start_at_edge();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic wait_spi_ack();
    for (int i = 0; i < 700; i++) begin
      @(posedge clk_sys); #1;
      if (spi_ack0) break;
    end
  endtask

  task automatic wait_stat_ack();
    for (int i = 0; i < 700; i++) begin
      @(posedge clk_sys); #1;
      if (stat_ack0) break;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 700; i++) begin
      @(posedge clk_sys); #1;
      if (clr_done0) break;
    end
  endtask

  int s, n0, b0, d0;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_wr_en",    wr_en0,    0);
    chk("rst_wr_addr",  wr_addr0,  0);
    chk("rst_wr_data",  wr_data0,  0);
    chk("rst_spi_ack",  spi_ack0,  0);
    chk("rst_stat_ack", stat_ack0, 0);
    chk("rst_clr_busy", clr_busy0, 0);
    chk("rst_clr_done", clr_done0, 0);
    @(posedge clk_sys); @(posedge clk_sys); #2 rst = 1'b0;
    repeat (2) start_at_edge();

    // Single SPI write.
    spi_addr = 12'h021; spi_data = 8'h41; spi_req = 1'b1; s = cyc; n0 = wr_count;
    wait_spi_ack();
    chk("t1_ack_seen", spi_ack0, 1);
    chk("t1_latency",  cyc - s, 1);
    chk("t1_wr_en",    wr_en0, 1);
    chk("t1_wr_addr",  wr_addr0, 12'h021);
    chk("t1_wr_data",  wr_data0, 8'h41);
    start_at_edge(); spi_req = 1'b0;
    repeat (4) start_at_edge();
    chk("t1_write_count", wr_count - n0, 1);

    // Single status write.
    stat_addr = 12'h3E0; stat_data = 8'h55; stat_req = 1'b1; n0 = wr_count;
    wait_stat_ack();
    chk("t2_ack_seen", stat_ack0, 1);
    chk("t2_wr_addr",  wr_addr0, 12'h3E0);
    chk("t2_wr_data",  wr_data0, 8'h55);
    start_at_edge(); stat_req = 1'b0;
    repeat (4) start_at_edge();
    chk("t2_write_count", wr_count - n0, 1);

    // Both held: alternate one write per cycle, SPI first (stat was granted last).
    spi_addr = 12'h100; spi_data = 8'hA1; stat_addr = 12'h200; stat_data = 8'hB2;
    spi_req = 1'b1; stat_req = 1'b1; n0 = wr_count;
    repeat (10) start_at_edge();
    spi_req = 1'b0; stat_req = 1'b0;
    repeat (3) start_at_edge();
    chk("t3_write_count", wr_count - n0, 10);
    for (int k = 0; k < 10; k++)
      chk("t3_order", wr_log[(n0 + k) % 8192], (k % 2 == 0) ? 12'h100 : 12'h200);

    // Fill with 0x20; SPI request raised at fill write 100.
    clr_char = 8'h20; clr_start = 1'b1; s = cyc; n0 = wr_count; b0 = busy_count;
    start_at_edge(); clr_start = 1'b0; clr_char = 8'h00;
    repeat (101) @(posedge clk_sys);
    #2 spi_addr = 12'h123; spi_data = 8'h77; spi_req = 1'b1;
    wait_spi_ack();
    chk("t4_ack_seen",  spi_ack0, 1);
    chk("t4_ack_cycle", cyc - s, TB_BYTES + 3);
    chk("t4_wr_addr",   wr_addr0, 12'h123);
    chk("t4_wr_data",   wr_data0, 8'h77);
    start_at_edge(); spi_req = 1'b0;
    repeat (3) start_at_edge();
    chk("t4_write_count", wr_count - n0, TB_BYTES + 1);
    chk("t4_busy_cycles", busy_count - b0, TB_BYTES);
    chk("t4_done_cycle",  done_cyc - s, TB_BYTES + 2);
    chk("t4_first_addr",  wr_log[n0 % 8192], 12'h000);
    chk("t4_last_addr",   wr_log[(n0 + 511) % 8192], 12'h1FF);
    chk("t4_fill_data",   wr_dlog[(n0 + 300) % 8192], 8'h20);
    chk("t4_b_first",     wr_log1[n0 % 8192], 12'hF00);
    chk("t4_b_pre_wrap",  wr_log1[(n0 + 255) % 8192], 12'hFFF);
    chk("t4_b_wrap",      wr_log1[(n0 + 256) % 8192], 12'h000);
    chk("t4_b_last",      wr_log1[(n0 + 511) % 8192], 12'h0FF);

    // clr_start and a status request in the same cycle: fill first, then status.
    clr_char = 8'h2A; clr_start = 1'b1; s = cyc;
    stat_addr = 12'h0AB; stat_data = 8'hCD; stat_req = 1'b1;
    start_at_edge(); clr_start = 1'b0;
    wait_stat_ack();
    chk("t5_ack_seen",  stat_ack0, 1);
    chk("t5_ack_cycle", cyc - s, TB_BYTES + 3);
    chk("t5_wr_addr",   wr_addr0, 12'h0AB);
    start_at_edge(); stat_req = 1'b0;
    repeat (3) start_at_edge();

    // Reset during fill write 200.
    clr_char = 8'h55; clr_start = 1'b1; s = cyc;
    start_at_edge(); clr_start = 1'b0;
    repeat (201) @(posedge clk_sys);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_wr_en",   wr_en0, 0);
    chk("t6_rst_busy",    clr_busy0, 0);
    chk("t6_rst_addr",    wr_addr0, 0);
    chk("t6_rst_data",    wr_data0, 0);
    chk("t6_rst_b_addr",  wr_addr1, 0);
    d0 = done_count;
    @(posedge clk_sys); @(posedge clk_sys); #2 rst = 1'b0;
    repeat (600) start_at_edge();
    chk("t6_no_done", done_count - d0, 0);

    // Full fill after reset; a second clr_start mid-fill must be ignored.
    clr_char = 8'h2E; clr_start = 1'b1; s = cyc; n0 = wr_count; b0 = busy_count;
    start_at_edge(); clr_start = 1'b0; clr_char = 8'hFF;
    repeat (51) @(posedge clk_sys);
    #2 clr_char = 8'h99; clr_start = 1'b1;
    start_at_edge(); clr_start = 1'b0;
    wait_done();
    chk("t7_done_seen",  clr_done0, 1);
    chk("t7_done_cycle", cyc - s, TB_BYTES + 2);
    repeat (3) start_at_edge();
    chk("t7_write_count", wr_count - n0, TB_BYTES);
    chk("t7_busy_cycles", busy_count - b0, TB_BYTES);
    chk("t7_last_data",   wr_dlog[(n0 + 511) % 8192], 8'h2E);
    chk("t7_last_addr",   wr_log[(n0 + 511) % 8192], 12'h1FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
